// File: rtl/axis_phase_to_sine_if.sv
// AXI4-Stream bundle (tdata/tvalid/tready) shared by the phase input and sample output.
interface axis_phase_to_sine_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_phase_to_sine.sv
// Streaming phase-to-sine converter: quarter-wave table, 3-stage pipeline with a single
// global enable so back-pressure freezes every stage together.
module axis_phase_to_sine #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 16,
    parameter int PHASE_WIDTH        = 30,
    parameter int LUT_BITS           = 10,
    parameter int AMP_WIDTH          = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_phase_to_sine_if.slave  s_axis,
    axis_phase_to_sine_if.master m_axis
);

    localparam int LUT_DEPTH = 2 ** LUT_BITS;

    // Sample the first quadrant at bin centres so mirrored addresses reproduce the
    // second quadrant exactly and no entry lands on zero.
    function automatic logic [AMP_WIDTH-1:0] sine_entry(input int k);
        real amp;
        real ang;
        amp = real'((2 ** (AMP_WIDTH - 1)) - 1);
        ang = (3.14159265358979323846 / 2.0) * (real'(k) + 0.5) / real'(LUT_DEPTH);
        return AMP_WIDTH'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    logic [AMP_WIDTH-1:0] lut [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam logic [AMP_WIDTH-1:0] ENTRY = sine_entry(k);
        assign lut[k] = ENTRY;
    end

    logic                 phase_half;
    logic                 phase_mirror;
    logic [LUT_BITS-1:0]  phase_raw;
    logic                 unused_bits;

    assign phase_half   = s_axis.tdata[PHASE_WIDTH-1];
    assign phase_mirror = s_axis.tdata[PHASE_WIDTH-2];
    assign phase_raw    = s_axis.tdata[PHASE_WIDTH-3 -: LUT_BITS];
    assign unused_bits  = ^s_axis.tdata;

    logic [LUT_BITS-1:0]  s1_addr_q,  s1_addr_d;
    logic                 s1_half_q,  s1_half_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [AMP_WIDTH-1:0] s2_amp_q,   s2_amp_d;
    logic                 s2_half_q,  s2_half_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [AMP_WIDTH-1:0] s3_data_q,  s3_data_d;
    logic                 s3_valid_q, s3_valid_d;
    logic                 ce;

    // An empty output slot lets the pipeline advance even while downstream is not ready.
    assign ce            = m_axis.tready | ~s3_valid_q;
    assign s_axis.tready = ce;

    always_comb begin
        s1_addr_d  = s1_addr_q;
        s1_half_d  = s1_half_q;
        s1_valid_d = s1_valid_q;
        s2_amp_d   = s2_amp_q;
        s2_half_d  = s2_half_q;
        s2_valid_d = s2_valid_q;
        s3_data_d  = s3_data_q;
        s3_valid_d = s3_valid_q;
        if (ce) begin
            s1_valid_d = s_axis.tvalid;
            if (s_axis.tvalid) begin
                s1_addr_d = phase_raw ^ {LUT_BITS{phase_mirror}};
                s1_half_d = phase_half;
            end
            s2_amp_d   = lut[s1_addr_q];
            s2_half_d  = s1_half_q;
            s2_valid_d = s1_valid_q;
            s3_data_d  = s2_half_q ? -s2_amp_q : s2_amp_q;
            s3_valid_d = s2_valid_q;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_addr_q  <= '0;
            s1_half_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_amp_q   <= '0;
            s2_half_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_addr_q  <= s1_addr_d;
            s1_half_q  <= s1_half_d;
            s1_valid_q <= s1_valid_d;
            s2_amp_q   <= s2_amp_d;
            s2_half_q  <= s2_half_d;
            s2_valid_q <= s2_valid_d;
            s3_data_q  <= s3_data_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    assign m_axis.tvalid = s3_valid_q;
    assign m_axis.tdata  = M_AXIS_TDATA_WIDTH'($signed(s3_data_q));

endmodule

// File: tb/tb_axis_phase_to_sine.sv
// Directed bench for axis_phase_to_sine: latency, truncation, bubbles, back-pressure,
// full coarse sweep against a full-wave sine model, and asynchronous reset mid-stream.
module tb_axis_phase_to_sine;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    axis_phase_to_sine_if #(.DATA_WIDTH(32)) s_bus ();
    axis_phase_to_sine_if #(.DATA_WIDTH(16)) m_bus ();

    axis_phase_to_sine #(
        .S_AXIS_TDATA_WIDTH(32),
        .M_AXIS_TDATA_WIDTH(16),
        .PHASE_WIDTH(30),
        .LUT_BITS(10),
        .AMP_WIDTH(16)
    ) dut (
        .aclk   (clk),
        .areset (rst),
        .s_axis (s_bus),
        .m_axis (m_bus)
    );

    // Full-wave model over the 4096 coarse phases, independent of the quarter-wave folding.
    function automatic logic [15:0] golden(input logic [31:0] w);
        int  c;
        int  m;
        real v;
        c = int'(w[29:18]);
        v = 32767.0 * $sin(2.0 * PI * (real'(c) + 0.5) / 4096.0);
        if (v < 0.0) m = -$rtoi(-v + 0.5);
        else         m = $rtoi(v + 0.5);
        return 16'(m);
    endfunction

    task automatic test_reset();
        rst          = 1'b1;
        s_bus.tvalid = 1'b0;
        s_bus.tdata  = '0;
        m_bus.tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (m_bus.tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset tvalid: got %b expected 0", m_bus.tvalid);
        end
        checks++;
        if (m_bus.tdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset tdata: got %h expected 0000", m_bus.tdata);
        end
        checks++;
        if (s_bus.tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset s_tready: got %b expected 1", s_bus.tready);
        end
        rst          = 1'b0;
        m_bus.tready = 1'b1;
    endtask

    // Four quadrant corners back to back; each result must appear exactly 3 cycles later.
    task automatic test_latency();
        logic [31:0] vin  [4];
        logic [15:0] vexp [4];
        int          k;
        vin  = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
        vexp = '{16'h0019, 16'h7FFF, 16'hFFE7, 16'h8001};
        m_bus.tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            k = c - 3;
            checks++;
            if (m_bus.tvalid !== ((k >= 0 && k < 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("[TB] FAIL latency tvalid cycle %0d: got %b", c, m_bus.tvalid);
            end
            if (k >= 0 && k < 4) begin
                checks++;
                if (m_bus.tdata !== vexp[k]) begin
                    errors++;
                    $display("[TB] FAIL latency tdata[%0d]: got %h expected %h", k, m_bus.tdata, vexp[k]);
                end
            end
            s_bus.tvalid = (c < 4);
            s_bus.tdata  = (c < 4) ? vin[c] : 32'h0;
        end
        s_bus.tvalid = 1'b0;
    endtask

    task automatic test_upper_bits();
        logic [31:0] vin  [2];
        logic [15:0] vexp [2];
        int          k;
        vin  = '{32'hC000_0000, 32'h3FFF_FFFF};
        vexp = '{16'h0019, 16'hFFE7};
        m_bus.tready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            k = c - 3;
            if (k >= 0 && k < 2) begin
                checks++;
                if (m_bus.tvalid !== 1'b1 || m_bus.tdata !== vexp[k]) begin
                    errors++;
                    $display("[TB] FAIL upper_bits[%0d]: got v=%b %h expected v=1 %h",
                             k, m_bus.tvalid, m_bus.tdata, vexp[k]);
                end
            end
            s_bus.tvalid = (c < 2);
            s_bus.tdata  = (c < 2) ? vin[c] : 32'h0;
        end
        s_bus.tvalid = 1'b0;
    endtask

    task automatic test_bubbles();
        logic        pat  [3];
        logic [31:0] vin  [3];
        logic [15:0] vexp [3];
        int          k;
        logic        exp_v;
        pat  = '{1'b1, 1'b0, 1'b1};
        vin  = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
        vexp = '{16'h7FFF, 16'h0000, 16'h8001};
        m_bus.tready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            #1;
            k = c - 3;
            exp_v = (k >= 0 && k < 3) ? pat[k] : 1'b0;
            checks++;
            if (m_bus.tvalid !== exp_v) begin
                errors++;
                $display("[TB] FAIL bubbles tvalid cycle %0d: got %b expected %b", c, m_bus.tvalid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (m_bus.tdata !== vexp[k]) begin
                    errors++;
                    $display("[TB] FAIL bubbles tdata[%0d]: got %h expected %h", k, m_bus.tdata, vexp[k]);
                end
            end
            s_bus.tvalid = (c < 3) ? pat[c] : 1'b0;
            s_bus.tdata  = (c < 3) ? vin[c] : 32'h0;
        end
        s_bus.tvalid = 1'b0;
    endtask

    task automatic test_back_pressure();
        localparam int N = 400;
        logic [15:0] expq [$];
        logic [15:0] held = '0;
        logic [15:0] e;
        bit          stalled = 1'b0;
        int          idx = 0;
        int          got = 0;
        int          cyc = 0;
        while (got < N && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                checks++;
                if (m_bus.tvalid !== 1'b1 || m_bus.tdata !== held) begin
                    errors++;
                    $display("[TB] FAIL stall_hold cycle %0d: got v=%b %h expected v=1 %h",
                             cyc, m_bus.tvalid, m_bus.tdata, held);
                end
            end
            m_bus.tready = 1'($urandom_range(0, 1));
            s_bus.tvalid = (idx < N);
            s_bus.tdata  = 32'(idx) << 20;
            #1;
            if (s_bus.tvalid && s_bus.tready) begin
                expq.push_back(golden(s_bus.tdata));
                idx++;
            end
            if (m_bus.tvalid && m_bus.tready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL back_pressure extra sample: got %h expected none", m_bus.tdata);
                end else begin
                    e = expq.pop_front();
                    if (m_bus.tdata !== e) begin
                        errors++;
                        $display("[TB] FAIL back_pressure sample %0d: got %h expected %h", got, m_bus.tdata, e);
                    end
                end
                got++;
            end
            stalled = m_bus.tvalid && !m_bus.tready;
            held    = m_bus.tdata;
        end
        checks++;
        if (got != N || expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL back_pressure count: got %0d samples, %0d pending, expected %0d and 0",
                     got, expq.size(), N);
        end
        s_bus.tvalid = 1'b0;
        m_bus.tready = 1'b1;
    endtask

    // Every coarse phase with random fraction and ignored upper bits; then half-wave symmetry.
    task automatic test_sweep();
        logic [15:0] expq [$];
        logic [15:0] outs [4096];
        logic [15:0] e;
        logic [15:0] sum;
        int          idx = 0;
        int          got = 0;
        int          cyc = 0;
        m_bus.tready = 1'b1;
        while (got < 4096 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            s_bus.tvalid = (idx < 4096);
            s_bus.tdata  = {2'($urandom_range(0, 3)), 12'(idx), 18'($urandom)};
            #1;
            if (s_bus.tvalid && s_bus.tready) begin
                expq.push_back(golden(s_bus.tdata));
                idx++;
            end
            if (m_bus.tvalid) begin
                checks++;
                e = (expq.size() != 0) ? expq.pop_front() : 16'hxxxx;
                if (m_bus.tdata !== e) begin
                    errors++;
                    $display("[TB] FAIL sweep phase %0d: got %h expected %h", got, m_bus.tdata, e);
                end
                outs[got] = m_bus.tdata;
                got++;
            end
        end
        s_bus.tvalid = 1'b0;
        checks++;
        if (got != 4096) begin
            errors++;
            $display("[TB] FAIL sweep timeout: got %0d samples expected 4096", got);
        end else begin
            for (int c = 0; c < 2048; c++) begin
                checks++;
                sum = outs[c] + outs[c + 2048];
                if (sum !== 16'h0000) begin
                    errors++;
                    $display("[TB] FAIL symmetry %0d: got %h and %h, sum %h expected 0000",
                             c, outs[c], outs[c + 2048], sum);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        m_bus.tready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            s_bus.tvalid = 1'b1;
            s_bus.tdata  = 32'(c + 1) << 26;
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_bus.tvalid !== 1'b1 || s_bus.tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_reset stall: got v=%b s_tready=%b expected v=1 s_tready=0",
                     m_bus.tvalid, s_bus.tready);
        end
        rst          = 1'b1;
        s_bus.tvalid = 1'b0;
        #1;
        checks++;
        if (m_bus.tvalid !== 1'b0 || m_bus.tdata !== 16'h0000 || s_bus.tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b %h s_tready=%b expected v=0 0000 s_tready=1",
                     m_bus.tvalid, m_bus.tdata, s_bus.tready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (m_bus.tvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stale_sample cycle %0d: got v=%b %h expected v=0", c, m_bus.tvalid, m_bus.tdata);
            end
        end
        m_bus.tready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (c >= 1) begin
                checks++;
                if (c == 3) begin
                    if (m_bus.tvalid !== 1'b1 || m_bus.tdata !== 16'h7FFF) begin
                        errors++;
                        $display("[TB] FAIL post_reset first: got v=%b %h expected v=1 7fff",
                                 m_bus.tvalid, m_bus.tdata);
                    end
                end else if (m_bus.tvalid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL post_reset cycle %0d: got v=%b expected v=0", c, m_bus.tvalid);
                end
            end
            s_bus.tvalid = (c == 0);
            s_bus.tdata  = 32'h1000_0000;
        end
        s_bus.tvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_upper_bits();
        test_bubbles();
        test_back_pressure();
        test_sweep();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_phase_to_sine.md
# axis_phase_to_sine

Streaming phase-to-amplitude converter that consumes the phase-accumulator AXI4-Stream (signed-extended phase words) and produces signed sine samples. Uses a quarter-wave lookup table with a 3-stage pipeline and full AXI4-Stream back-pressure. It sits directly downstream of the phase generator, feeding mixers and DAC paths.

## Interface
- S_AXIS_TDATA_WIDTH, 32: input word width; phase occupies bits [PHASE_WIDTH-1:0], upper bits ignored.
- M_AXIS_TDATA_WIDTH, 16: output word width; amplitude sign-extended to fill it; must be >= AMP_WIDTH.
- PHASE_WIDTH, 30: phase accumulator width; must be >= LUT_BITS+2.
- LUT_BITS, 10: quarter-wave table address width (2^LUT_BITS entries).
- AMP_WIDTH, 16: signed amplitude width.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  S_AXIS_TDATA_WIDTH  phase word.
- s_axis_tvalid  in  1  phase word valid.
- s_axis_tready  out  1  converter accepts phase word.
- m_axis_tdata  out  M_AXIS_TDATA_WIDTH  signed sine sample.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  downstream accepts sample.

## Operation
- Phase decode: p = s_axis_tdata[PHASE_WIDTH-1:0]; half = p[PHASE_WIDTH-1]; mirror = p[PHASE_WIDTH-2]; raw = p[PHASE_WIDTH-3 -: LUT_BITS]; lower PHASE_WIDTH-2-LUT_BITS bits truncated (no rounding, no dither).
- Address = raw XOR {LUT_BITS{mirror}}.
- Table entry k = round((2^(AMP_WIDTH-1)-1) * sin(pi/2 * (k+0.5) / 2^LUT_BITS)), k = 0..2^LUT_BITS-1; all entries positive, max 2^(AMP_WIDTH-1)-1; built at elaboration (constant function or init file), read synchronously.
- Output = half ? -entry : entry; negation never overflows (no entry equals -min).
- m_axis_tdata = sign-extended AMP_WIDTH result.
- Pipeline: S1 registers address, half, valid; S2 registers table read, half, valid; S3 registers signed result, valid (drives m_axis_*).
- Global enable ce = m_axis_tready | ~m_axis_tvalid; all three stages advance only when ce = 1; s_axis_tready = ce (combinational from m_axis_tready and S3 valid).
- Input handshake: word captured into S1 when s_axis_tvalid & ce; S1 valid <= s_axis_tvalid on ce.
- Bubbles propagate as invalid slots; no reordering, no drops, no duplication.

## Timing
- Reset (async assert, sync-safe release): all valid flags 0, all data registers 0; m_axis_tvalid = 0, m_axis_tdata = 0, s_axis_tready = 1.
- Latency: input accepted at edge N appears on m_axis_tdata/tvalid after edge N+2 (visible in cycle N+3) with m_axis_tready held high.
- Throughput: one sample per cycle while m_axis_tready = 1.
- Stall: m_axis_tvalid = 1 & m_axis_tready = 0 -> s_axis_tready = 0, all stage registers and m_axis_tdata hold; m_axis_tdata stable while tvalid high and not accepted.
- Output register empty (m_axis_tvalid = 0) -> pipeline advances regardless of m_axis_tready.
- Simultaneous m_axis_tready rise and new s_axis_tvalid: word accepted same cycle.
- Reset mid-stream: in-flight samples discarded; first post-reset output comes from first post-reset accepted input.
- Phase wrap (all-ones -> 0): continuous; no special handling.

## Test plan
- Defaults, m_axis_tready = 1, inputs 0, 2^28, 2^29, 3*2^28 on consecutive cycles -> outputs 25, 32767, -25, -32767 (0x0019, 0x7FFF, 0xFFE7, 0x8001), each 3 cycles after acceptance, back-to-back.
- Upper bits ignored: input 0xC000_0000 -> output 25; input 0x3FFF_FFFF -> output -25.
- Back-pressure: continuous valid ramp (step 2^20), m_axis_tready random 50% -> output sequence equals golden model in order, no loss/duplication; tdata stable during every stall cycle.
- Bubbles: s_axis_tvalid toggling 1,0,1 with m_axis_tready = 1 -> m_axis_tvalid 1,0,1 pattern delayed 3 cycles.
- Full sweep: all 2^(LUT_BITS+2) coarse phases -> matches golden table, quadrant symmetry exact (out(x) = -out(x + 2^29)).
- Reset mid-stream with pipeline full and m_axis_tready = 0 -> m_axis_tvalid falls to 0 immediately (asynchronous), s_axis_tready = 1 after reset, no stale sample emitted.
